// File: rtl/sersub_pkg.sv
// ============================================================================
// Module      : sersub_pkg
// Description : Shared types and constants for the bit-serial subtractor.
//               Holds the FSM state encoding and the default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sersub_pkg;

  // Default operand/result width for serial_subtractor.
  localparam int SERSUB_DEFAULT_WIDTH = 4;

  // Controller states, fixed 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sersub_state_t;

endpackage : sersub_pkg

`default_nettype wire

// File: rtl/full_subtractor.sv
// ============================================================================
// Module      : full_subtractor
// Description : Purely combinational 1-bit full-subtractor cell computing
//               x - y - bi.
// Ports       : x  - minuend bit
//               y  - subtrahend bit
//               bi - borrow in
//               d  - difference bit
//               bo - borrow out
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor
  import sersub_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  // Borrow when y exceeds x outright, or when they are equal and a borrow
  // is already pending from the less significant bit.
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule : full_subtractor

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial A - B - Bin engine. One bit per clock, LSB first,
//               through a single full_subtractor cell and a registered
//               borrow. start/busy/done handshake; result held until the
//               next operation completes.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               start - request, sampled only in IDLE
//               a, b  - minuend / subtrahend, captured on acceptance
//               bin   - borrow in, captured on acceptance
//               diff  - a - b - bin modulo 2^WIDTH
//               bout  - borrow out of the MSB (unsigned underflow)
//               busy  - high while the bit loop runs
//               done  - one-cycle pulse, diff/bout valid from this cycle on
//               ovf   - signed overflow flag (only with SERSUB_OVF_EN)
// Options     : SERSUB_OVF_EN - adds the ovf output and its logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
  import sersub_pkg::*;
#(
  parameter int WIDTH = SERSUB_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
`ifdef SERSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sersub_state_t    state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic bit_d;
  logic bit_bo;

  full_subtractor u_cell (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .bi (br),
    .d  (bit_d),
    .bo (bit_bo)
  );

`ifdef SERSUB_OVF_EN
  // Operand sign bits are shifted out during the loop, so keep copies.
  logic a_msb;
  logic b_msb;
`endif

  // The visible outputs (done/diff/bout) are registered from the DONE state,
  // so they all change together on the edge that leaves DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef SERSUB_OVF_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef SERSUB_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
          end
        end

        RUN: begin
          // Result fills from the MSB end so bit 0 lands at res[0] after
          // WIDTH shifts.
          res  <= {bit_d, res[WIDTH-1:1]};
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          br   <= bit_bo;
          if (cnt == LAST_BIT) begin
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          done  <= 1'b1;
          diff  <= res;
          bout  <= br;
          busy  <= 1'b0;
          state <= IDLE;
`ifdef SERSUB_OVF_EN
          ovf <= (a_msb ^ b_msb) & (res[WIDTH-1] ^ a_msb);
`endif
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : serial_subtractor

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking directed bench for serial_subtractor (WIDTH=4).
//               Covers reset, handshake timing, directed vectors, held start,
//               asynchronous reset mid-operation, optional overflow flag
//               (SERSUB_OVF_EN) and all 512 operand combinations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       bin;
  logic [3:0] diff;
  logic       bout;
  logic       busy;
  logic       done;
`ifdef SERSUB_OVF_EN
  logic       ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .diff  (diff),
    .bout  (bout),
    .busy  (busy),
    .done  (done)
`ifdef SERSUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation and wait (bounded) for its done pulse.
  // Returns at the negedge on which done is observed high.
  task automatic run_op(input logic [3:0] ia, input logic [3:0] ib,
                        input logic ibin, output bit ok);
    @(negedge clk);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (done === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = 4'h0; b = 4'h0; bin = 1'b0;
    #1;
    n_checks++;
    if ({diff, bout, busy, done} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_async: got diff=%h bout=%b busy=%b done=%b, want all 0",
               diff, bout, busy, done);
    end
    @(posedge clk); @(negedge clk);
    n_checks++;
    if ({diff, bout, busy, done} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_clocked: got diff=%h bout=%b busy=%b done=%b, want all 0",
               diff, bout, busy, done);
    end
    rst_n = 1'b1;
  endtask

  // 5 - 3: busy after edges 0..3, done only after edge 5.
  task automatic test_basic_timing();
    logic exp_busy;
    logic exp_done;
    @(negedge clk);
    a = 4'd5; b = 4'd3; bin = 1'b0; start = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      exp_busy = (k <= 3);
      exp_done = (k == 5);
      n_checks++;
      if (busy !== exp_busy || done !== exp_done) begin
        n_fail++;
        $display("FAIL timing_edge%0d: got busy=%b done=%b, want busy=%b done=%b",
                 k, busy, done, exp_busy, exp_done);
      end
      if (k == 5) begin
        n_checks++;
        if (diff !== 4'd2 || bout !== 1'b0) begin
          n_fail++;
          $display("FAIL basic_5m3: got diff=%h bout=%b, want diff=2 bout=0", diff, bout);
        end
      end
    end
    n_checks++;
    if (diff !== 4'd2) begin
      n_fail++;
      $display("FAIL basic_hold: got diff=%h after done, want 2", diff);
    end
  endtask

  task automatic test_vectors();
    bit ok;
    run_op(4'd3, 4'd5, 1'b0, ok);
    n_checks++;
    if (!ok || diff !== 4'hE || bout !== 1'b1) begin
      n_fail++;
      $display("FAIL vec_3m5: got ok=%b diff=%h bout=%b, want diff=e bout=1", ok, diff, bout);
    end
    run_op(4'd0, 4'd0, 1'b1, ok);
    n_checks++;
    if (!ok || diff !== 4'hF || bout !== 1'b1) begin
      n_fail++;
      $display("FAIL vec_0m0m1: got ok=%b diff=%h bout=%b, want diff=f bout=1", ok, diff, bout);
    end
    run_op(4'd15, 4'd15, 1'b0, ok);
    n_checks++;
    if (!ok || diff !== 4'h0 || bout !== 1'b0) begin
      n_fail++;
      $display("FAIL vec_15m15: got ok=%b diff=%h bout=%b, want diff=0 bout=0", ok, diff, bout);
    end
  endtask

  // start held high: 7-2 captured, operands changed to 12,4 during RUN,
  // which the re-accepted second operation then uses.
  task automatic test_back_to_back();
    int first_idx;
    int second_idx;
    @(negedge clk);
    a = 4'd7; b = 4'd2; bin = 1'b0; start = 1'b1;
    first_idx = -1; second_idx = -1;
    for (int k = 0; k < 30 && second_idx < 0; k++) begin
      @(negedge clk);
      if (k == 0) begin a = 4'd12; b = 4'd4; end
      if (done === 1'b1) begin
        if (first_idx < 0) begin
          first_idx = k;
          n_checks++;
          if (diff !== 4'd5 || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL held_first: got diff=%h bout=%b, want diff=5 bout=0", diff, bout);
          end
        end else begin
          second_idx = k;
          start = 1'b0;
          n_checks++;
          if (diff !== 4'd8 || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL held_second: got diff=%h bout=%b, want diff=8 bout=0", diff, bout);
          end
        end
      end
    end
    start = 1'b0;
    n_checks++;
    if (first_idx != 5 || second_idx - first_idx != 6) begin
      n_fail++;
      $display("FAIL held_spacing: got first=%0d second=%0d, want first=5 spacing=6",
               first_idx, second_idx);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    bit seen;
    @(negedge clk);
    a = 4'd5; b = 4'd1; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({diff, bout, busy, done} !== 7'b0) begin
      n_fail++;
      $display("FAIL midrun_reset: got diff=%h bout=%b busy=%b done=%b, want all 0",
               diff, bout, busy, done);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL abandoned_op: got activity=1 after reset, want 0");
    end
    run_op(4'd9, 4'd4, 1'b0, ok);
    n_checks++;
    if (!ok || diff !== 4'd5 || bout !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_9m4: got ok=%b diff=%h bout=%b, want diff=5 bout=0",
               ok, diff, bout);
    end
  endtask

  task automatic test_ovf();
`ifdef SERSUB_OVF_EN
    bit ok;
    run_op(4'b0111, 4'b1111, 1'b0, ok);
    n_checks++;
    if (!ok || diff !== 4'b1000 || bout !== 1'b1 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_7m15: got diff=%b bout=%b ovf=%b, want diff=1000 bout=1 ovf=1",
               diff, bout, ovf);
    end
    run_op(4'b0011, 4'b0001, 1'b0, ok);
    n_checks++;
    if (!ok || diff !== 4'b0010 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_3m1: got diff=%b ovf=%b, want diff=0010 ovf=0", diff, ovf);
    end
`endif
  endtask

  task automatic test_exhaustive();
    bit         ok;
    logic [4:0] exp;
    logic [3:0] ta;
    logic [3:0] tb;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          ta  = 4'(ia);
          tb  = 4'(ib);
          exp = 5'((ia - ib - ic) & 31);
          run_op(ta, tb, 1'(ic), ok);
          n_checks++;
          if (!ok || {bout, diff} !== exp) begin
            n_fail++;
            $display("FAIL exh_%0d_%0d_%0d: got ok=%b {bout,diff}=%h, want %h",
                     ia, ib, ic, ok, {bout, diff}, exp);
          end
`ifdef SERSUB_OVF_EN
          n_checks++;
          if (ovf !== ((ta[3] != tb[3]) && (exp[3] != ta[3]))) begin
            n_fail++;
            $display("FAIL exh_ovf_%0d_%0d_%0d: got ovf=%b", ia, ib, ic, ovf);
          end
`endif
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_timing();
    test_vectors();
    test_back_to_back();
    test_async_reset();
    test_ovf();
    test_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_subtractor

`default_nettype wire
